// File: rtl/instruction_fetch_buffer.sv
// instruction_fetch_buffer
//
// Decoupling queue between the instruction memory and the issue controller.
// Owns the fetch PC, drives the imem address, and enqueues one aligned block
// of FETCH_WIDTH words per cycle whenever that many slots are free. The
// oldest ISSUE_WIDTH entries are presented, each with its PC, to the issuer,
// which consumes a variable number of them per cycle. A redirect flushes the
// queue and restarts fetch from redirect_pc.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   imem_addr        : fetch PC (combinational from the fetch-PC register)
//   imem_data        : FETCH_WIDTH words, word k is the instr at imem_addr+4k
//   redirect_valid   : flush queue, restart fetch at redirect_pc
//   redirect_pc      : new fetch PC
//   deq_count        : entries consumed from the head this cycle
//   out_instr/out_pc : ISSUE_WIDTH slots, slot j is the entry at head+j
//   out_valid_count  : min(count, ISSUE_WIDTH)
//   count            : current occupancy

module instruction_fetch_buffer #(
    parameter int          FETCH_WIDTH = 8,
    parameter int          DEPTH       = 16,
    parameter int          ISSUE_WIDTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    localparam int         PTR_W       = $clog2(DEPTH),
    localparam int         CNT_W       = $clog2(DEPTH + 1),
    localparam int         DQ_W        = $clog2(ISSUE_WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              imem_addr,
    input  logic [FETCH_WIDTH*32-1:0] imem_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic [DQ_W-1:0]          deq_count,
    output logic [ISSUE_WIDTH*32-1:0] out_instr,
    output logic [ISSUE_WIDTH*32-1:0] out_pc,
    output logic [DQ_W-1:0]          out_valid_count,
    output logic [CNT_W-1:0]         count
);

    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] occ;
    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];

    logic [DQ_W-1:0]  deq_eff;
    logic [CNT_W:0]   space;
    logic             enq;

    assign imem_addr = fetch_pc;
    assign count     = occ;

    assign out_valid_count = (occ >= CNT_W'(ISSUE_WIDTH)) ? DQ_W'(ISSUE_WIDTH) : DQ_W'(occ);

    // Over-requests are clamped to what is actually visible.
    assign deq_eff = (deq_count < out_valid_count) ? deq_count : out_valid_count;

    // Free space counts the slots released by this cycle's dequeue, so a full
    // queue can still accept a block when the issuer drains enough of it.
    // One extra bit holds DEPTH + ISSUE_WIDTH without overflow.
    assign space = (CNT_W + 1)'(DEPTH) - {1'b0, occ} + (CNT_W + 1)'(deq_eff);
    assign enq   = (space >= (CNT_W + 1)'(FETCH_WIDTH));

    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            out_instr[j*32 +: 32] = instr_mem[head + PTR_W'(j)];
            out_pc[j*32 +: 32]    = pc_mem[head + PTR_W'(j)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (redirect_valid) begin
            // Storage is left intact; out_valid_count=0 hides stale entries.
            fetch_pc <= redirect_pc;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
        end else begin
            head <= head + PTR_W'(deq_eff);
            if (enq) begin
                for (int k = 0; k < FETCH_WIDTH; k++) begin
                    instr_mem[tail + PTR_W'(k)] <= imem_data[k*32 +: 32];
                    pc_mem[tail + PTR_W'(k)]    <= fetch_pc + 32'(4 * k);
                end
                tail     <= tail + PTR_W'(FETCH_WIDTH);
                fetch_pc <= fetch_pc + 32'(4 * FETCH_WIDTH);
                occ      <= occ - CNT_W'(deq_eff) + CNT_W'(FETCH_WIDTH);
            end else begin
                occ      <= occ - CNT_W'(deq_eff);
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Testbench for instruction_fetch_buffer: table of directed vectors with
// hand-derived count/address/head-PC expectations, a queue model feeding a
// scoreboard that checks every visible slot, a 32-bit PC wrap sequence and
// a randomised tail phase.

module tb_instruction_fetch_buffer;

    localparam int          FW    = 8;
    localparam int          DEPTH = 16;
    localparam int          IW    = 8;
    localparam logic [31:0] RPC   = 32'h0000_3000;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       imem_addr;
    logic [FW*32-1:0]  imem_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [3:0]        deq_count;
    logic [IW*32-1:0]  out_instr;
    logic [IW*32-1:0]  out_pc;
    logic [3:0]        out_valid_count;
    logic [4:0]        count;
    logic [31:0]       salt;

    always #5 clk = ~clk;

    instruction_fetch_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .deq_count       (deq_count),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_valid_count (out_valid_count),
        .count           (count)
    );

    // Memory contents depend on address and a per-cycle salt, so any write
    // while the queue is full would show up as changed instruction words.
    always_comb begin
        imem_data = '0;
        for (int k = 0; k < FW; k++)
            imem_data[k*32 +: 32] = (imem_addr + 32'(4 * k)) ^ salt;
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        int          cnt;
        logic [31:0] addr;
        int          ovc;
        logic [31:0] ins [IW];
        logic [31:0] pcs [IW];
        bit          zero;
    } exp_t;

    typedef struct {
        bit          r;
        bit          rv;
        logic [31:0] rpc;
        int          dq;
        int          ecount;
        logic [31:0] eaddr;
        bit          chk_pc0;
        logic [31:0] epc0;
    } vec_t;

    ent_t        mq[$];
    exp_t        sb[$];
    logic [31:0] mpc;
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input int dq);
        exp_t e;
        exp_t g;
        int   ovc;
        int   d;
        bit   en;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        deq_count      = 4'(dq);
        salt           = $urandom;
        if (r) begin
            mq.delete();
            mpc = RPC;
        end else if (rv) begin
            mq.delete();
            mpc = rpc;
        end else begin
            ovc = (mq.size() < IW) ? mq.size() : IW;
            d   = (dq < ovc) ? dq : ovc;
            en  = (DEPTH - mq.size() + d) >= FW;
            repeat (d) void'(mq.pop_front());
            if (en) begin
                for (int k = 0; k < FW; k++)
                    mq.push_back({(mpc + 32'(4 * k)) ^ salt, mpc + 32'(4 * k)});
                mpc = mpc + 32'(4 * FW);
            end
        end
        e.cnt  = mq.size();
        e.addr = mpc;
        e.ovc  = (mq.size() < IW) ? mq.size() : IW;
        e.zero = r;
        for (int j = 0; j < IW; j++) begin
            e.ins[j] = (j < mq.size()) ? mq[j].instr : 32'h0;
            e.pcs[j] = (j < mq.size()) ? mq[j].pc    : 32'h0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("count", 32'(count), 32'(g.cnt));
        check("imem_addr", imem_addr, g.addr);
        check("out_valid_count", 32'(out_valid_count), 32'(g.ovc));
        for (int j = 0; j < IW; j++) begin
            if (j < g.ovc || g.zero) begin
                check($sformatf("out_instr[%0d]", j), out_instr[j*32 +: 32], g.ins[j]);
                check($sformatf("out_pc[%0d]", j), out_pc[j*32 +: 32], g.pcs[j]);
            end
        end
    endtask

    vec_t vecs[20];

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        deq_count      = 4'd0;
        salt           = 32'h0;
        mpc            = RPC;

        //         r  rv  rpc            dq  count addr          chk  pc0
        vecs[0]  = '{1, 0, 32'h0,         0,  0,  32'h0000_3000, 1, 32'h0};
        vecs[1]  = '{1, 1, 32'h0000_3100, 0,  0,  32'h0000_3000, 1, 32'h0};
        vecs[2]  = '{0, 0, 32'h0,         0,  8,  32'h0000_3020, 1, 32'h0000_3000};
        vecs[3]  = '{0, 0, 32'h0,         0,  16, 32'h0000_3040, 1, 32'h0000_3000};
        vecs[4]  = '{0, 0, 32'h0,         0,  16, 32'h0000_3040, 1, 32'h0000_3000};
        vecs[5]  = '{0, 0, 32'h0,         0,  16, 32'h0000_3040, 1, 32'h0000_3000};
        vecs[6]  = '{0, 0, 32'h0,         8,  16, 32'h0000_3060, 1, 32'h0000_3020};
        vecs[7]  = '{0, 0, 32'h0,         8,  16, 32'h0000_3080, 1, 32'h0000_3040};
        vecs[8]  = '{0, 0, 32'h0,         8,  16, 32'h0000_30A0, 1, 32'h0000_3060};
        vecs[9]  = '{0, 0, 32'h0,         8,  16, 32'h0000_30C0, 1, 32'h0000_3080};
        vecs[10] = '{0, 0, 32'h0,         8,  16, 32'h0000_30E0, 1, 32'h0000_30A0};
        vecs[11] = '{0, 0, 32'h0,         8,  16, 32'h0000_3100, 1, 32'h0000_30C0};
        vecs[12] = '{0, 0, 32'h0,         8,  16, 32'h0000_3120, 1, 32'h0000_30E0};
        vecs[13] = '{0, 0, 32'h0,         4,  12, 32'h0000_3120, 1, 32'h0000_30F0};
        vecs[14] = '{0, 1, 32'h0000_3100, 4,  0,  32'h0000_3100, 0, 32'h0};
        vecs[15] = '{0, 0, 32'h0,         8,  8,  32'h0000_3120, 1, 32'h0000_3100};
        vecs[16] = '{0, 0, 32'h0,         15, 8,  32'h0000_3140, 1, 32'h0000_3120};
        vecs[17] = '{0, 0, 32'h0,         0,  16, 32'h0000_3160, 1, 32'h0000_3120};
        vecs[18] = '{0, 0, 32'h0,         7,  9,  32'h0000_3160, 1, 32'h0000_313C};
        vecs[19] = '{0, 0, 32'h0,         15, 9,  32'h0000_3180, 1, 32'h0000_315C};

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].r, vecs[i].rv, vecs[i].rpc, vecs[i].dq);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecount));
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].eaddr);
            if (vecs[i].chk_pc0)
                check($sformatf("vec%0d_pc0", i), out_pc[31:0], vecs[i].epc0);
        end

        // 32-bit fetch-PC wraparound
        step(0, 1, 32'hFFFF_FFF0, 0);
        check("wrap_redirect_addr", imem_addr, 32'hFFFF_FFF0);
        step(0, 0, 32'h0, 0);
        check("wrap_addr", imem_addr, 32'h0000_0010);
        check("wrap_pc3", out_pc[3*32 +: 32], 32'hFFFF_FFFC);
        check("wrap_pc4", out_pc[4*32 +: 32], 32'h0000_0000);

        // Randomised traffic against the queue model
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0)
                step(0, 1, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 15));
            else
                step(0, 0, 32'h0, $urandom_range(0, 15));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
